// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Build option: ARB_LOCK_EN (see arbiter_round_robin.sv).
package arbiter_pkg;

  // Arbiter FSM encoding.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  // Width of a requester index for n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage : arbiter_pkg

// File: rtl/arbiter_rr_pick.sv
// Combinational round-robin pick: finds the first set request searching
// upward from a start index with wrap-around. The request vector is rotated
// so the start index lands on bit 0, priority-encoded, and the offset is
// added back to the start index.
module arbiter_rr_pick
  import arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] winner
);

  logic [N-1:0] req_rot;
  logic [W-1:0] offset;
  logic         any_set;

  // Index arithmetic modulo N with an explicit compare, so non-power-of-two
  // N wraps correctly.
  function automatic int wrap_add(input int a, input int b);
    int sum;
    sum = a + b;
    return (sum >= N) ? (sum - N) : sum;
  endfunction

  // Rotate so that the start index becomes bit 0.
  always_comb begin
    req_rot = '0;
    for (int i = 0; i < N; i++) begin
      req_rot[i] = req[wrap_add(int'(start), i)];
    end
  end

  // Lowest set bit of the rotated vector is the closest requester after start.
  always_comb begin
    any_set = 1'b0;
    offset  = '0;
    for (int i = 0; i < N; i++) begin
      if (!any_set && req_rot[i]) begin
        any_set = 1'b1;
        offset  = W'(i);
      end
    end
  end

  // Map the offset back to an absolute requester index.
  always_comb begin
    found  = any_set;
    winner = '0;
    if (any_set) begin
      winner = W'(wrap_add(int'(start), int'(offset)));
    end
  end

endmodule : arbiter_rr_pick

// File: rtl/arbiter_round_robin.sv
// Round-robin arbiter with registered one-hot grant and a per-tenure hold
// limit. A released tenure hands over to the next winner on the same edge,
// so there is no idle cycle between owners.
// Build option ARB_LOCK_EN: adds a lock input that lets a still-requesting
// owner keep the grant past the hold limit.
//
// state    | meaning
// ---------+-----------------------------------------------
// ARB_IDLE | no owner, grant outputs all zero
// ARB_OWN  | grant held by grant_id, hold_cnt counts tenure
module arbiter_round_robin
  import arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req,
`ifdef ARB_LOCK_EN
  input  logic                    lock,
`endif
  output logic [N-1:0]            grant,
  output logic                    grant_valid,
  output logic [idx_width(N)-1:0] grant_id
);

  localparam int W  = idx_width(N);
  localparam int HW = cnt_width(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [W-1:0]  IDX_LAST  = W'(N - 1);

  arb_state_t    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          valid_q, valid_d;
  logic [W-1:0]  id_q, id_d;
  logic [W-1:0]  ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;

  logic          pick_found;
  logic [W-1:0]  pick_winner;
  logic          owner_req;
  logic          hold_hit;
  logic          lock_keep;
  logic          release_own;

  // The owner sits at ptr-1, so searching from ptr gives it lowest priority
  // while still letting it win when nobody else is requesting.
  arbiter_rr_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .req    (req),
    .start  (ptr_q),
    .found  (pick_found),
    .winner (pick_winner)
  );

  assign owner_req = req[id_q];
  assign hold_hit  = (hold_q == HOLD_LAST);

`ifdef ARB_LOCK_EN
  assign lock_keep = lock & owner_req;
`else
  assign lock_keep = 1'b0;
`endif

  // Owner drop and hold expiry collapse into one release event.
  assign release_own = !owner_req || (hold_hit && !lock_keep);

  // Next-state, next-grant and rotation pointer.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    valid_d = valid_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_OWN;
          grant_d = N'(1) << pick_winner;
          valid_d = 1'b1;
          id_d    = pick_winner;
          hold_d  = '0;
          ptr_d   = (pick_winner == IDX_LAST) ? '0 : pick_winner + 1'b1;
        end else begin
          grant_d = '0;
          valid_d = 1'b0;
          id_d    = '0;
          hold_d  = '0;
        end
      end

      ARB_OWN: begin
        if (!release_own) begin
          // Saturate rather than wrap; only reachable at the limit under lock.
          hold_d = hold_hit ? hold_q : hold_q + HW'(1);
        end else if (pick_found) begin
          state_d = ARB_OWN;
          grant_d = N'(1) << pick_winner;
          valid_d = 1'b1;
          id_d    = pick_winner;
          hold_d  = '0;
          ptr_d   = (pick_winner == IDX_LAST) ? '0 : pick_winner + 1'b1;
        end else begin
          state_d = ARB_IDLE;
          grant_d = '0;
          valid_d = 1'b0;
          id_d    = '0;
          hold_d  = '0;
        end
      end

      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        valid_d = 1'b0;
        id_d    = '0;
        hold_d  = '0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;

endmodule : arbiter_round_robin

// File: tb/tb_arbiter_round_robin.sv
// Directed bench for arbiter_round_robin with N=4, MAX_HOLD=4. Expected
// grants are hand-derived and queued when each step is driven, then popped
// and compared one cycle later.
module tb_arbiter_round_robin;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
`ifdef ARB_LOCK_EN
  logic         lock = 1'b0;
`endif
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_id;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0] g;
    string        tag;
  } exp_t;

  exp_t exp_q[$];

  arbiter_round_robin #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
`ifdef ARB_LOCK_EN
    .lock        (lock),
`endif
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] id_of(input logic [N-1:0] g);
    logic [1:0] id;
    id = 2'd0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) id = 2'(i);
    end
    return id;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input logic r, input logic [N-1:0] rq,
                      input logic [N-1:0] eg, input string tag);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    exp_q.push_back('{g: eg, tag: tag});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    assert (grant === e.g) else begin
      failures++;
      $error("FAIL %s grant got=%b exp=%b", e.tag, grant, e.g);
    end
    checks++;
    assert (grant_valid === (|e.g)) else begin
      failures++;
      $error("FAIL %s grant_valid got=%b exp=%b", e.tag, grant_valid, |e.g);
    end
    checks++;
    assert (grant_id === id_of(e.g)) else begin
      failures++;
      $error("FAIL %s grant_id got=%0d exp=%0d", e.tag, grant_id, id_of(e.g));
    end
  endtask

  initial begin
    // Reset held with all requesting: no grant.
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 4'b0000, "reset_hold");

    // Fair rotation, four cycles per owner, no gaps, wrap back to 0.
    for (int i = 0; i < 17; i++)
      step(1'b0, 4'b1111, 4'(1 << ((i / 4) % 4)), "rotation");

    // Owner 0 kept a second cycle, then drops; req2 takes over with no bubble.
    step(1'b0, 4'b0001, 4'b0001, "early_keep");
    step(1'b0, 4'b0100, 4'b0100, "early_release");

    // Lone requester 1 keeps being re-granted across hold expiries.
    for (int i = 0; i < 12; i++) step(1'b0, 4'b0010, 4'b0010, "lone_req");
    step(1'b0, 4'b0000, 4'b0000, "lone_drop");
    step(1'b0, 4'b0000, 4'b0000, "idle");

    // Pointer stayed at 2 while idle.
    step(1'b0, 4'b1101, 4'b0100, "idle_ptr");

    // Owner 3, then mid-tenure reset.
    step(1'b0, 4'b1000, 4'b1000, "own3");
    step(1'b0, 4'b1000, 4'b1000, "own3_hold");
    step(1'b1, 4'b1000, 4'b0000, "mid_reset3");
    step(1'b0, 4'b1010, 4'b0010, "post_reset3");

    // Owner 1 leaves ptr at 2; reset must restart the search at 0.
    step(1'b0, 4'b1010, 4'b0010, "own1_hold");
    step(1'b1, 4'b1010, 4'b0000, "mid_reset1");
    step(1'b0, 4'b1010, 4'b0010, "post_reset1");
    step(1'b0, 4'b0000, 4'b0000, "drop_all");

`ifdef ARB_LOCK_EN
    // From idle with ptr=2, req=0011 picks 0; lock keeps it past the limit.
    lock = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 4'b0011, 4'b0001, "lock_keep");
    lock = 1'b0;
    step(1'b0, 4'b0011, 4'b0010, "lock_release");
    step(1'b0, 4'b0011, 4'b0010, "after_lock");
    step(1'b0, 4'b0000, 4'b0000, "lock_drop");
`endif

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_arbiter_round_robin
